// File: rtl/instr_decoder.sv
// instr_decoder: registered RV32I field, immediate and ALU-op decoder with one cycle of latency
module instr_decoder #(
    parameter int N               = 32,
    parameter int ALU_FUNCT_WIDTH = 4,
    parameter int INSTR_REG_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               instr,
    input  logic                       controlOverride,
    output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
    output logic [INSTR_REG_WIDTH-1:0] rs1,
    output logic [INSTR_REG_WIDTH-1:0] rs2,
    output logic [INSTR_REG_WIDTH-1:0] rd,
    output logic [N-1:0]               immed
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    logic [6:0]                 opcode;
    logic [2:0]                 funct3;
    logic [31:0]                imm32;
    logic [3:0]                 alu4;
    logic [ALU_FUNCT_WIDTH-1:0] alu_funct_d, alu_funct_q;
    logic [INSTR_REG_WIDTH-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [N-1:0]               immed_d, immed_q;
    always_comb begin
        opcode = instr[6:0];
        funct3 = instr[14:12];
        alu4 = controlOverride     ? 4'b0000 :
               opcode == OP_REG    ? {instr[30], funct3} :
               opcode == OP_IMM    ? {(funct3 == 3'b101) & instr[30], funct3} :
               opcode == OP_BRANCH ? 4'b1000 : 4'b0000;
        imm32 = (opcode == OP_LOAD || opcode == OP_IMM || opcode == OP_JALR) ? {{20{instr[31]}}, instr[31:20]} :
                opcode == OP_STORE  ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                opcode == OP_BRANCH ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                (opcode == OP_LUI || opcode == OP_AUIPC) ? {instr[31:12], 12'b0} :
                opcode == OP_JAL    ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} : 32'b0;
        alu_funct_d = ALU_FUNCT_WIDTH'(alu4);
        rs1_d = INSTR_REG_WIDTH'(instr[19:15]);
        rs2_d = INSTR_REG_WIDTH'(instr[24:20]);
        rd_d = INSTR_REG_WIDTH'(instr[11:7]);
        immed_d = N'($signed(imm32));
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_funct_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q <= '0;
            immed_q <= '0;
        end else begin
            alu_funct_q <= alu_funct_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            rd_q <= rd_d;
            immed_q <= immed_d;
        end
    end
    assign alu_funct = alu_funct_q;
    assign rs1 = rs1_q;
    assign rs2 = rs2_q;
    assign rd = rd_q;
    assign immed = immed_q;
endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: vector table, reset/pipelining sequences and randomized checks against a reference model
module tb_instr_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        ovr = 1'b0;
    logic [3:0]  alu_funct;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] immed;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] instr;
        logic        ovr;
        logic [3:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
    } vec_t;

    instr_decoder dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .controlOverride(ovr),
        .alu_funct(alu_funct), .rs1(rs1), .rs2(rs2), .rd(rd), .immed(immed)
    );

    always #5 clk = ~clk;

    // Immediates are rebuilt as weighted bit sums minus the sign weight.
    function automatic vec_t model(logic [31:0] w, logic o);
        vec_t e;
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [31:0] sgn = w[31] ? 32'd1 : 32'd0;
        e.instr = w;
        e.ovr = o;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd = w[11:7];
        case (op)
            7'h03, 7'h13, 7'h67: e.imm = 32'(w[30:20]) - sgn * 2048;
            7'h23: e.imm = 32'(w[30:25]) * 32 + 32'(w[11:7]) - sgn * 2048;
            7'h63: e.imm = 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2 + 32'(w[7]) * 2048 - sgn * 4096;
            7'h37, 7'h17: e.imm = w & 32'hFFFFF000;
            7'h6F: e.imm = 32'(w[30:21]) * 2 + 32'(w[20]) * 2048 + 32'(w[19:12]) * 4096 - sgn * 32'h100000;
            default: e.imm = 32'd0;
        endcase
        if (o) e.alu = 4'd0;
        else if (op == 7'h33) e.alu = {w[30], f3};
        else if (op == 7'h13) e.alu = (f3 == 3'd5) ? {w[30], 3'd5} : {1'b0, f3};
        else if (op == 7'h63) e.alu = 4'b1000;
        else e.alu = 4'd0;
        return e;
    endfunction

    function automatic vec_t zero_vec();
        vec_t e;
        e.instr = '0; e.ovr = 1'b0; e.alu = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.imm = '0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input vec_t e);
        chk({name, ".alu"}, 32'(alu_funct), 32'(e.alu));
        chk({name, ".rs1"}, 32'(rs1), 32'(e.rs1));
        chk({name, ".rs2"}, 32'(rs2), 32'(e.rs2));
        chk({name, ".rd"}, 32'(rd), 32'(e.rd));
        chk({name, ".imm"}, immed, e.imm);
    endtask

    task automatic apply(input logic [31:0] w, input logic o, input logic r);
        @(negedge clk);
        instr = w;
        ovr = o;
        rst_n = r;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[6];
    vec_t prev, cur;
    logic [6:0] ops[10];

    initial begin
        tbl[0] = '{32'hFFF00093, 1'b0, 4'b0000, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF};
        tbl[1] = '{32'h402081B3, 1'b0, 4'b1000, 5'd1, 5'd2, 5'd3, 32'h00000000};
        tbl[2] = '{32'h4030D093, 1'b0, 4'b1101, 5'd1, 5'd3, 5'd1, 32'h00000403};
        tbl[3] = '{32'h4030D093, 1'b1, 4'b0000, 5'd1, 5'd3, 5'd1, 32'h00000403};
        tbl[4] = '{32'h0020A423, 1'b1, 4'b0000, 5'd1, 5'd2, 5'd8, 32'h00000008};
        tbl[5] = '{32'h123452B7, 1'b0, 4'b0000, 5'd8, 5'd3, 5'd5, 32'h12345000};
        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};

        apply(32'hFFFFFFFF, 1'b0, 1'b0);
        chk_all("reset1", zero_vec());
        apply(32'hFFFFFFFF, 1'b0, 1'b0);
        chk_all("reset2", zero_vec());
        @(negedge clk);
        instr = tbl[0].instr;
        ovr = tbl[0].ovr;
        rst_n = 1'b1;
        #1;
        chk_all("pre_release", zero_vec());
        @(posedge clk);
        #1;
        chk_all("first_decode", tbl[0]);

        foreach (tbl[i]) begin
            apply(tbl[i].instr, tbl[i].ovr, 1'b1);
            chk_all($sformatf("vec%0d", i), tbl[i]);
        end

        // Alternate SW and LUI; outputs must hold the previous word until the edge.
        prev = tbl[5];
        for (int i = 0; i < 6; i++) begin
            cur = tbl[(i % 2 == 0) ? 4 : 5];
            @(negedge clk);
            instr = cur.instr;
            ovr = cur.ovr;
            #1;
            chk_all($sformatf("b2b_hold%0d", i), prev);
            @(posedge clk);
            #1;
            chk_all($sformatf("b2b%0d", i), cur);
            prev = cur;
        end

        apply(tbl[1].instr, 1'b0, 1'b0);
        chk_all("midreset", zero_vec());
        apply(tbl[5].instr, 1'b0, 1'b1);
        chk_all("after_midreset", tbl[5]);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] w;
            logic o, r;
            w = $urandom;
            w[6:0] = ops[$urandom_range(9)];
            if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
            o = ($urandom_range(3) == 0);
            r = ($urandom_range(15) != 0);
            apply(w, o, r);
            chk_all($sformatf("rnd%0d", i), r ? model(w, o) : zero_vec());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_decoder.md
# instr_decoder

Registered RV32I instruction-field decoder in the Philosophy-V datapath, between instruction fetch and the register file/ALU. It extracts the register addresses, produces the sign-extended immediate for the instruction format, and encodes the ALU operation. A control-path override forces the ALU to ADD for address and PC arithmetic. All outputs are registered with one cycle of latency.

## Interface
- N, default 32: instruction and immediate width.
- ALU_FUNCT_WIDTH, default 4: ALU function code width.
- INSTR_REG_WIDTH, default 5: register address width.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  reset; synchronous, active-low.
- instr  in  N  raw 32-bit instruction word.
- controlOverride  in  1  1 forces alu_funct to ADD.
- alu_funct  out  ALU_FUNCT_WIDTH  ALU operation code.
- rs1  out  INSTR_REG_WIDTH  source register 1 = instr[19:15].
- rs2  out  INSTR_REG_WIDTH  source register 2 = instr[24:20].
- rd  out  INSTR_REG_WIDTH  destination register = instr[11:7].
- immed  out  N  sign-extended immediate.

## Operation
- rs1, rs2 and rd are always the raw instruction fields, regardless of opcode or validity.
- ALU codes, {bit3, funct3}:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111
- alu_funct priority:
  1. controlOverride=1: ADD (0000), for any opcode.
  2. OP (opcode 0110011): {instr[30], instr[14:12]}.
  3. OP-IMM (0010011): funct3=101 gives {instr[30], 101}; any other funct3 gives {0, funct3}, so instr[30] is ignored.
  4. BRANCH (1100011): SUB (1000).
  5. Any other opcode: ADD (0000).
- Immediate by opcode (opcode = instr[6:0]); all immediates are sign-extended from instr[31]:
  - I-type (0000011 LOAD, 0010011 OP-IMM, 1100111 JALR): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111 LUI, 0010111 AUIPC): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type and unrecognised opcodes: 0.
- Shift immediates are not masked. SRAI yields the full I-immediate, including bit 10.
- There is no illegal-instruction detection. Unknown opcodes decode per the defaults above.

## Timing
- All outputs are registered and update on the rising edge of clk.
- Latency is 1 cycle: instr and controlOverride sampled at edge k appear on the outputs after edge k.
- Reset: rst_n=0 at a rising edge forces alu_funct, rs1, rs2, rd and immed to 0 on that edge. Reset has priority over decode.
- Reset mid-stream discards the instruction sampled on that edge. The first decode after rst_n returns to 1 appears one edge later.
- No handshake; a new instruction is accepted every cycle. Back-to-back instructions are never stalled or merged.
- Inputs must be stable around the rising edge. Decode logic is combinational between the input pins and the output registers.

## Test plan
- Reset: rst_n=0 for 2 cycles with instr=0xFFFFFFFF → all outputs 0; first decode appears the edge after rst_n=1.
- ADDI x1,x0,-1 (0xFFF00093), override=0 → alu_funct=0000, rs1=0, rs2=31, rd=1, immed=0xFFFFFFFF.
- SUB x3,x1,x2 (0x402081B3), override=0 → alu_funct=1000, rs1=1, rs2=2, rd=3, immed=0.
- SRAI x1,x1,3 (0x4030D093) → alu_funct=1101, immed=0x00000403. Same word with override=1 → alu_funct=0000.
- SW x2,8(x1) (0x0020A423), override=1 → alu_funct=0000, rs1=1, rs2=2, rd=8, immed=8.
- LUI x5,0x12345 (0x123452B7) → immed=0x12345000, rd=5, alu_funct=0000.
- Back-to-back: alternate the two previous words every cycle → each result appears exactly one cycle after its input.
